fp32_stream_accumulator: RTL and testbench

//  Downstream of the fp16->fp32 adder stage. Consumes its fp32 sums as a valid/ready stream
//  and accumulates them into one fp32 result per group. A group ends on in_last or after
//  MAX_TERMS beats. The result is handed out on a valid/ready output and held until accepted.
//  Dot-product style reductions use it: mul -> 16->32 add -> this block.

---
 rtl/fp_acc_pkg.sv | 36 +++
 rtl/fp32_stream_accumulator_if.sv | 38 +++
 rtl/fp32_add_rne.sv | 129 ++++++++++++
 rtl/fp32_stream_accumulator.sv | 83 ++++++++
 tb/tb_fp32_stream_accumulator.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/fp_acc_pkg.sv
// Shared types and constants for the fp32 stream accumulator.
// Build option: FP_ACC_SUBNORM_EN selects gradual underflow over flush-to-zero.
package fp_acc_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
  localparam logic [31:0] FP32_NINF = 32'hFF80_0000;

  typedef enum logic {
    ACC,
    HOLD
  } acc_state_t;

  function automatic logic [4:0] lzc27(
    input logic [26:0] v
  );
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_stream_accumulator_if.sv
// Input beat stream and output result stream of the accumulator.
// master = producer/consumer side, slave = accumulator side.
interface fp32_stream_accumulator_if #(
  parameter int CNT_W = 9
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_count
  );

endinterface

// File: rtl/fp32_add_rne.sv
// Combinational binary32 adder, round-to-nearest-even.
// FP_ACC_SUBNORM_EN: gradual underflow; otherwise flush-to-zero.
module fp32_add_rne
  import fp_acc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  fp32_t fa, fb;
  assign fa = a;
  assign fb = b;

  logic [7:0]  ea, eb;
  logic [23:0] siga, sigb;

  assign ea = (fa.exp == 8'd0) ? 8'd1 : fa.exp;
  assign eb = (fb.exp == 8'd0) ? 8'd1 : fb.exp;

`ifdef FP_ACC_SUBNORM_EN
  assign siga = {fa.exp != 8'd0, fa.man};
  assign sigb = {fb.exp != 8'd0, fb.man};
`else
  assign siga = (fa.exp == 8'd0) ? 24'd0 : {1'b1, fa.man};
  assign sigb = (fb.exp == 8'd0) ? 24'd0 : {1'b1, fb.man};
`endif

  logic a_nan, b_nan, a_inf, b_inf;
  logic a_zero, b_zero;

  assign a_nan  = (fa.exp == 8'hFF) && (fa.man != 23'd0);
  assign b_nan  = (fb.exp == 8'hFF) && (fb.man != 23'd0);
  assign a_inf  = (fa.exp == 8'hFF) && (fa.man == 23'd0);
  assign b_inf  = (fb.exp == 8'hFF) && (fb.man == 23'd0);
  assign a_zero = (siga == 24'd0);
  assign b_zero = (sigb == 24'd0);

  logic        a_big;
  logic        big_s;
  logic [7:0]  big_e, sml_e, d;
  logic [23:0] big_sig, sml_sig;
  logic [4:0]  dsh;
  logic [53:0] wide;
  logic [26:0] aligned;
  logic        eff_sub;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [4:0]  shift;
  logic [26:0] norm;
  logic signed [9:0] e_pre;
  logic        rnd;
  logic [30:0] packed_r;

  assign a_big   = {ea, siga} >= {eb, sigb};
  assign big_s   = a_big ? fa.sign : fb.sign;
  assign big_e   = a_big ? ea : eb;
  assign sml_e   = a_big ? eb : ea;
  assign big_sig = a_big ? siga : sigb;
  assign sml_sig = a_big ? sigb : siga;
  assign eff_sub = fa.sign ^ fb.sign;

  // Alignment keeps G/R bits and folds everything lower into sticky.
  assign d       = big_e - sml_e;
  assign dsh     = (d > 8'd27) ? 5'd27 : d[4:0];
  assign wide    = {sml_sig, 30'd0} >> dsh;
  assign aligned = {wide[53:28], wide[27] | (|wide[26:0])};

  assign sum = eff_sub
             ? {1'b0, big_sig, 3'b000} - {1'b0, aligned}
             : {1'b0, big_sig, 3'b000} + {1'b0, aligned};

  assign lz = lzc27(sum[26:0]);

  always_comb begin
    shift = 5'd0;
    norm  = 27'd0;
    e_pre = 10'sd0;
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      e_pre = 10'({2'b00, big_e}) + 10'sd1;
    end else begin
`ifdef FP_ACC_SUBNORM_EN
      if ({3'b000, lz} < big_e) begin
        shift = lz;
        e_pre = 10'({2'b00, big_e}) - 10'({5'd0, lz});
      end else begin
        shift = 5'(big_e - 8'd1);
        e_pre = 10'sd0;
      end
`else
      shift = lz;
      e_pre = 10'({2'b00, big_e}) - 10'({5'd0, lz});
`endif
      norm = sum[26:0] << shift;
    end
  end

  // Carry out of the fraction walks into the exponent field.
  assign rnd      = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign packed_r = {e_pre[7:0], norm[25:3]} + 31'(rnd);

  logic unused_hidden;
  assign unused_hidden = norm[26];

  always_comb begin
    y = {big_s, packed_r};
    if (a_nan || b_nan) begin
      y = FP32_QNAN;
    end else if (a_inf && b_inf) begin
      y = eff_sub ? FP32_QNAN : a;
    end else if (a_inf) begin
      y = a;
    end else if (b_inf) begin
      y = b;
    end else if (a_zero && b_zero) begin
      y = {fa.sign & fb.sign, 31'd0};
    end else if (sum == 28'd0) begin
      y = 32'd0;
    end else if (e_pre >= 10'sd255) begin
      y = big_s ? FP32_NINF : FP32_PINF;
`ifndef FP_ACC_SUBNORM_EN
    end else if (e_pre < 10'sd1) begin
      y = {big_s, 31'd0};
`endif
    end
  end

endmodule

// File: rtl/fp32_stream_accumulator.sv
// Sums an fp32 beat stream into one result per group (in_last or MAX_TERMS).
// Build option: FP_ACC_SUBNORM_EN (passed through to fp32_add_rne).
module fp32_stream_accumulator
  import fp_acc_pkg::*;
#(
  parameter int  MAX_TERMS = 256,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input logic clk,
  input logic rstn,
  fp32_stream_accumulator_if.slave bus
);

  acc_state_t       state_q, state_d;
  logic [31:0]      acc_q, acc_d, sum;
  logic [CNT_W-1:0] count_q, count_inc;
  logic [31:0]      out_data_q;
  logic [CNT_W-1:0] out_count_q;
  logic             in_ready, out_valid;
  logic             fire, close, drain;

  fp32_add_rne u_add (
    .a (acc_q),
    .b (bus.in_data),
    .y (sum)
  );

  assign count_inc = count_q + CNT_W'(1);
  assign acc_d     = (count_q == '0) ? bus.in_data : sum;
  assign close     = bus.in_last
                   | (count_inc == CNT_W'(MAX_TERMS));
  assign fire      = bus.in_valid && (state_q == ACC);
  assign drain     = bus.out_ready && (state_q == HOLD);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (bus.in_valid && close) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = ACC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ACC;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q       <= 32'd0;
      count_q     <= '0;
      out_data_q  <= 32'd0;
      out_count_q <= '0;
    end else begin
      if (fire) begin
        acc_q   <= acc_d;
        count_q <= count_inc;
        if (close) begin
          out_data_q  <= acc_d;
          out_count_q <= count_inc;
        end
      end
      if (drain) begin
        acc_q   <= 32'd0;
        count_q <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_fp32_stream_accumulator.sv
// Directed bench for fp32_stream_accumulator with MAX_TERMS=4.
// Expected subnormal result follows FP_ACC_SUBNORM_EN.
module tb_fp32_stream_accumulator;

  localparam int MT = 4;
  localparam int CW = $clog2(MT + 1);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] held;

  fp32_stream_accumulator_if #(.CNT_W(CW)) bus ();

  fp32_stream_accumulator #(.MAX_TERMS(MT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic pair(input string tag,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] e);
    beat(a, 1'b0);
    beat(b, 1'b1);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk(tag, bus.out_data, e);
    take();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);

    beat(32'h3F80_0000, 1'b0);
    beat(32'h4000_0000, 1'b0);
    chk("basic_early", 32'(bus.out_valid), 32'd0);
    beat(32'h4040_0000, 1'b1);
    chk("basic_valid", 32'(bus.out_valid), 32'd1);
    chk("basic_data", bus.out_data, 32'h40C0_0000);
    chk("basic_count", 32'(bus.out_count), 32'd3);
    take();
    chk("basic_drop", 32'(bus.out_valid), 32'd0);
    chk("basic_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < MT; i++) beat(32'h3F80_0000, 1'b0);
    chk("auto_valid", 32'(bus.out_valid), 32'd1);
    chk("auto_data", bus.out_data, 32'h4080_0000);
    chk("auto_count", 32'(bus.out_count), 32'd4);
    chk("auto_ready", 32'(bus.in_ready), 32'd0);

    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_data", bus.out_data, held);
      chk("bp_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
    end
    take();
    chk("bp_drop", 32'(bus.out_valid), 32'd0);
    chk("bp_rearm", 32'(bus.in_ready), 32'd1);

    pair("ovf", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    pair("inf_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    pair("cancel", 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
    pair("neg_zero", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    pair("inf_fin", 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000);
    pair("ninf_fin", 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000);
    pair("rne_tie", 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    pair("rne_up", 32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001);
    pair("sub_norm", 32'h3FC0_0000, 32'hBF80_0000, 32'h3F00_0000);

    beat(32'h3F80_0000, 1'b0);
    beat(32'h7F80_0001, 1'b0);
    beat(32'h3F80_0000, 1'b1);
    chk("nan_data", bus.out_data, 32'h7FC0_0000);
    chk("nan_count", 32'(bus.out_count), 32'd3);
    take();

`ifdef FP_ACC_SUBNORM_EN
    pair("denorm", 32'h0000_0001, 32'h0000_0001, 32'h0000_0002);
`else
    pair("denorm", 32'h0000_0001, 32'h0000_0001, 32'h0000_0000);
`endif

    beat(32'h3F80_0000, 1'b0);
    beat(32'h3F80_0000, 1'b0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    beat(32'h4000_0000, 1'b1);
    chk("mid_rst_out", 32'(bus.out_valid), 32'd1);
    chk("mid_rst_data", bus.out_data, 32'h4000_0000);
    chk("mid_rst_count", 32'(bus.out_count), 32'd1);
    take();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
